stack_arbiter: RTL

- Two-requester round-robin controller sharing one 16-bit, 8-entry register-file stack.
- Serialises push/pop requests and drives the stack's push/pop/value_in pins.
- Tracks occupancy and returns pop data with a one-cycle ack.
- Blocks illegal operations (push when full, pop when empty) so that the stack pointer never wraps.

---
 rtl/stack_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/stack_arbiter.sv
// Round-robin arbiter that serialises push/pop requests from two requesters onto one stack.
// Optional STACK_ARBITER_STATS_EN adds err_total, a saturating count of rejected operations.
module stack_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             op_a,
  input  logic [WIDTH-1:0] wdata_a,
  output logic             ack_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             err_a,
  input  logic             req_b,
  input  logic             op_b,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             ack_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             err_b,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_value_in,
  input  logic [WIDTH-1:0] stk_value_out,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
`ifdef STACK_ARBITER_STATS_EN
  ,
  output logic [7:0]       err_total
`endif
);

  typedef enum logic [1:0] {IDLE, OP, RESP} state_t;

  state_t           state;
  logic             win_b;
  logic             op_pop;
  logic             bad;
  logic             ptr_b;
  logic             grant_b;
  logic             sel_op;
  logic             sel_illegal;
  logic [WIDTH-1:0] sel_data;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Tie goes to the pointer side; a lone requester always wins.
  always_comb begin
    grant_b     = (req_a && req_b) ? ptr_b : req_b;
    sel_op      = grant_b ? op_b : op_a;
    sel_data    = grant_b ? wdata_b : wdata_a;
    sel_illegal = sel_op ? empty : full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      win_b        <= 1'b0;
      op_pop       <= 1'b0;
      bad          <= 1'b0;
      ptr_b        <= 1'b0;
      count        <= '0;
      stk_push     <= 1'b0;
      stk_pop      <= 1'b0;
      stk_value_in <= '0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      err_a        <= 1'b0;
      err_b        <= 1'b0;
      rdata_a      <= '0;
      rdata_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            win_b        <= grant_b;
            op_pop       <= sel_op;
            bad          <= sel_illegal;
            stk_push     <= !sel_op && !sel_illegal;
            stk_pop      <= sel_op && !sel_illegal;
            stk_value_in <= sel_illegal ? '0 : sel_data;
            state        <= OP;
          end
        end
        OP: begin
          stk_push     <= 1'b0;
          stk_pop      <= 1'b0;
          stk_value_in <= '0;
          // Rejected ops return zero data; a pop captures the top before it is removed.
          if (bad) begin
            if (win_b) rdata_b <= '0;
            else       rdata_a <= '0;
          end else if (op_pop) begin
            if (win_b) rdata_b <= stk_value_out;
            else       rdata_a <= stk_value_out;
            count <= count - CW'(1);
          end else begin
            count <= count + CW'(1);
          end
          ack_a <= !win_b;
          ack_b <= win_b;
          err_a <= !win_b && bad;
          err_b <= win_b && bad;
          state <= RESP;
        end
        RESP: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          err_a <= 1'b0;
          err_b <= 1'b0;
          ptr_b <= !win_b;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STACK_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_total <= '0;
    end else if (state == RESP && (err_a || err_b) && err_total != 8'hFF) begin
      err_total <= err_total + 8'd1;
    end
  end
`endif

endmodule
